// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrub engine for the ECC word memory.
// Owns the array address/WE/data mux. When idle it periodically reads one word,
// and if the array flags a correctable error it writes the voted word back so
// that every copy is refreshed. Host accesses always win and stall the scrubber.

module ecc_scrubber #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int INTERVAL = 16,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              pass_done,
    output logic              busy
);

    // The wait counter must hold INTERVAL-1; keep at least one bit for INTERVAL=1.
    localparam int WAIT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(INTERVAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;
    logic [WAIT_W-1:0] wait_q,       wait_d;
    logic [CNT_W-1:0]  err_count_q,  err_count_d;
    logic              pass_done_q,  pass_done_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic              advance;

    // Next-state logic: interval wait, read/sample, optional write-back, address advance.
    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr_q;
        wait_d       = wait_q;
        err_count_d  = err_count_q;
        pass_done_d  = 1'b0;
        data_d       = data_q;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (wait_q == '0) begin
                        state_d = ST_RD;
                        wait_d  = WAIT_RELOAD;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
            end
            ST_RD: begin
                // A host access owns the array this cycle, so nothing is sampled.
                if (!host_req) begin
                    data_d = mem_rdata;
                    if (mem_err) begin
                        state_d = ST_WR;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (host_req) begin
                    // A host write to the same word is newer than our voted copy.
                    if (host_we && (host_addr == scrub_addr_q)) begin
                        advance = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            state_d      = ST_IDLE;
            scrub_addr_d = scrub_addr_q + 1'b1;
            pass_done_d  = (scrub_addr_q == '1);
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            scrub_addr_q <= '0;
            wait_q       <= WAIT_RELOAD;
            err_count_q  <= '0;
            pass_done_q  <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            scrub_addr_q <= scrub_addr_d;
            wait_q       <= wait_d;
            err_count_q  <= err_count_d;
            pass_done_q  <= pass_done_d;
            data_q       <= data_d;
        end
    end

    // Array mux: the host always wins; otherwise the scrubber drives the array.
    always_comb begin
        mem_addr  = scrub_addr_q;
        mem_we    = (state_q == ST_WR);
        mem_wdata = data_q;
        if (host_req) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
        end
    end

    assign host_rdata = mem_rdata;
    assign err_count  = err_count_q;
    assign pass_done  = pass_done_q;
    assign busy       = (state_q == ST_RD) || (state_q == ST_WR);

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb_ecc_scrubber: directed bench for ecc_scrubber with a small behavioural ECC array.

module tb_ecc_scrubber;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int INTERVAL = 16;
    localparam int CNT_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic [DATA_W-1:0] host_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;
    logic [CNT_W-1:0]  err_count;
    logic              pass_done;
    logic              busy;

    logic [DATA_W-1:0] memArr [16];
    logic              memErr [16];
    logic [DATA_W-1:0] presetData [16];
    logic              presetErr [16];
    logic              errAll = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic              hostReq;
        logic              hostWe;
        logic [ADDR_W-1:0] hostAddr;
        logic [DATA_W-1:0] hostWdata;
        logic [ADDR_W-1:0] expAddr;
        logic              expWe;
        logic [DATA_W-1:0] expWdata;
        logic [DATA_W-1:0] expRdata;
    } vecT;

    vecT vecs [6];

    ecc_scrubber #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .err_count(err_count), .pass_done(pass_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Array model: reload presets while in reset; any write refreshes the word and clears its error.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                memArr[i] <= presetData[i];
                memErr[i] <= presetErr[i];
            end
        end else if (mem_we) begin
            memArr[mem_addr] <= mem_wdata;
            memErr[mem_addr] <= 1'b0;
        end
    end

    assign mem_rdata = memArr[mem_addr];
    assign mem_err   = errAll | memErr[mem_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vecT v);
        host_req   = v.hostReq;
        host_we    = v.hostWe;
        host_addr  = v.hostAddr;
        host_wdata = v.hostWdata;
    endtask

    task automatic setPresets();
        for (int i = 0; i < 16; i++) begin
            presetData[i] = {i[3:0], i[3:0]};
            presetErr[i]  = 1'b0;
        end
        errAll = 1'b0;
    endtask

    task automatic resetDut();
        rst_n    = 1'b0;
        enable   = 1'b0;
        host_req = 1'b0;
        host_we  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        int edges;
        int reads;
        int scrubWrites;
        int doneAt;
        int doneCount;
        logic prevBusy;

        vecs[0] = '{1'b0, 1'b0, 4'h3, 8'h55, 4'h0, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 4'h3, 8'h55, 4'h3, 1'b0, 8'h55, 8'h33};
        vecs[2] = '{1'b1, 1'b1, 4'h6, 8'h9A, 4'h6, 1'b1, 8'h9A, 8'h66};
        vecs[3] = '{1'b1, 1'b0, 4'h6, 8'h00, 4'h6, 1'b0, 8'h00, 8'h9A};
        vecs[4] = '{1'b1, 1'b0, 4'hF, 8'h12, 4'hF, 1'b0, 8'h12, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 4'hF, 8'h77, 4'h0, 1'b0, 8'h00, 8'h00};

        // Reset values and the combinational host/scrubber mux with scrubbing disabled.
        setPresets();
        resetDut();
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_pass_done", 32'(pass_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v]);
            #1;
            checkOutput($sformatf("vec%0d_mem_addr", v), 32'(mem_addr), 32'(vecs[v].expAddr));
            checkOutput($sformatf("vec%0d_mem_we", v), 32'(mem_we), 32'(vecs[v].expWe));
            checkOutput($sformatf("vec%0d_mem_wdata", v), 32'(mem_wdata), 32'(vecs[v].expWdata));
            checkOutput($sformatf("vec%0d_host_rdata", v), 32'(host_rdata), 32'(vecs[v].expRdata));
            @(negedge clk);
        end
        host_req = 1'b0;
        host_we  = 1'b0;

        // Clean pass: 16 reads, no write-backs, pass_done exactly once at edge 16*17.
        setPresets();
        resetDut();
        enable = 1'b1;
        reads = 0; scrubWrites = 0; doneAt = -1; doneCount = 0; prevBusy = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (busy && !prevBusy && c <= 272) reads++;
            prevBusy = busy;
            if (mem_we) scrubWrites++;
            if (pass_done) begin
                doneCount++;
                if (doneAt < 0) doneAt = c;
            end
        end
        checkOutput("clean_reads", 32'(reads), 32'd16);
        checkOutput("clean_writes", 32'(scrubWrites), 32'd0);
        checkOutput("clean_done_edge", 32'(doneAt), 32'd272);
        checkOutput("clean_done_pulses", 32'(doneCount), 32'd1);
        checkOutput("clean_err_count", 32'(err_count), 32'd0);

        // Correctable error at address 5: one write-back of the voted word.
        setPresets();
        presetData[5] = 8'hA5;
        presetErr[5]  = 1'b1;
        resetDut();
        enable = 1'b1;
        edges = 0;
        while (!mem_we && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("err5_wr_edge", 32'(edges), 32'd102);
        checkOutput("err5_mem_addr", 32'(mem_addr), 32'd5);
        checkOutput("err5_mem_wdata", 32'(mem_wdata), 32'hA5);
        checkOutput("err5_count_before", 32'(err_count), 32'd0);
        @(negedge clk);
        checkOutput("err5_we_one_cycle", 32'(mem_we), 32'd0);
        checkOutput("err5_count_after", 32'(err_count), 32'd1);
        checkOutput("err5_next_addr", 32'(mem_addr), 32'd6);
        checkOutput("err5_busy_after", 32'(busy), 32'd0);

        // Host holds the array for 3 cycles while the scrubber is reading address 2.
        setPresets();
        resetDut();
        enable = 1'b1;
        guard = 0;
        while (!(busy && mem_addr == 4'd2) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stall_reach_rd2", 32'(guard), 32'd50);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 4'h9;
        #1;
        checkOutput("stall_host_addr", 32'(mem_addr), 32'h9);
        checkOutput("stall_host_rdata", 32'(host_rdata), 32'h99);
        checkOutput("stall_host_we", 32'(mem_we), 32'd0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_busy%0d", s), 32'(busy), 32'd1);
        end
        host_req = 1'b0;
        #1;
        checkOutput("stall_resume_addr", 32'(mem_addr), 32'd2);
        checkOutput("stall_not_sampled", 32'(mem_wdata), 32'h11);
        @(negedge clk);
        checkOutput("stall_sampled", 32'(mem_wdata), 32'h22);
        checkOutput("stall_done_busy", 32'(busy), 32'd0);
        checkOutput("stall_next_addr", 32'(mem_addr), 32'd3);

        // Host write to address 7 while its write-back is pending cancels the write-back.
        setPresets();
        presetErr[7] = 1'b1;
        resetDut();
        enable = 1'b1;
        guard = 0;
        while (!(mem_we && mem_addr == 4'd7) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("cancel_reach_wr7", 32'(guard), 32'd136);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'h7;
        host_wdata = 8'h3C;
        #1;
        checkOutput("cancel_host_wdata", 32'(mem_wdata), 32'h3C);
        @(negedge clk);
        host_req = 1'b0;
        host_we  = 1'b0;
        #1;
        checkOutput("cancel_busy", 32'(busy), 32'd0);
        checkOutput("cancel_mem_we", 32'(mem_we), 32'd0);
        checkOutput("cancel_next_addr", 32'(mem_addr), 32'd8);
        checkOutput("cancel_err_count", 32'(err_count), 32'd0);
        scrubWrites = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_we) scrubWrites++;
        end
        checkOutput("cancel_no_late_write", 32'(scrubWrites), 32'd0);
        checkOutput("cancel_host_data_kept", 32'(memArr[7]), 32'h3C);

        // Every word in error for 300 words: the counter saturates at 255.
        setPresets();
        resetDut();
        errAll = 1'b1;
        enable = 1'b1;
        scrubWrites = 0;
        guard = 0;
        while (scrubWrites < 300 && guard < 7000) begin
            @(negedge clk);
            guard++;
            if (mem_we) begin
                scrubWrites++;
                if (scrubWrites == 255) checkOutput("sat_count_254", 32'(err_count), 32'd254);
            end
        end
        checkOutput("sat_writes_seen", 32'(scrubWrites), 32'd300);
        @(negedge clk);
        checkOutput("sat_count_255", 32'(err_count), 32'd255);
        errAll = 1'b0;

        // Reset asserted during a write-back: outputs drop at once, scrub restarts at 0.
        setPresets();
        presetErr[0] = 1'b1;
        resetDut();
        enable = 1'b1;
        guard = 0;
        while (!mem_we && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rstwr_reach_wr", 32'(guard), 32'd17);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstwr_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rstwr_busy", 32'(busy), 32'd0);
        checkOutput("rstwr_err_count", 32'(err_count), 32'd0);
        checkOutput("rstwr_pass_done", 32'(pass_done), 32'd0);
        checkOutput("rstwr_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rstwr_mem_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        while (!busy && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("rstwr_restart_edges", 32'(edges), 32'd16);
        checkOutput("rstwr_restart_addr", 32'(mem_addr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_scrubber.md
Name: ecc_scrubber

Overview:
- Background scrub engine for the ECC word memory built from ecc_mem_bit cells.
- Sits in front of the array: owns the address/WE/data mux between host and scrubber.
- Periodically reads one word; if the array flags a correctable error, writes back the corrected (voted) word to refresh all copies.
- Counts corrections and signals completion of each full pass.

Parameters:
- ADDR_W, 4, word address width; array depth = 2^ADDR_W.
- DATA_W, 8, word width.
- INTERVAL, 16, idle cycles between scrub accesses (>=1).
- CNT_W, 8, width of saturating correction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scrub enable.
- host_req  in  1  host access request this cycle; always wins.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  = mem_rdata (pass-through).
- mem_addr  out  ADDR_W  array address.
- mem_we  out  1  array write enable.
- mem_wdata  out  DATA_W  array write data.
- mem_rdata  in  DATA_W  corrected read data; combinational from mem_addr.
- mem_err  in  1  OR of per-bit err for the addressed word; combinational.
- err_count  out  CNT_W  saturating count of corrections performed.
- pass_done  out  1  one-cycle pulse at end of each full pass.
- busy  out  1  high in RD or WR.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, scrub_addr=0, wait counter=INTERVAL-1, err_count=0, pass_done=0, captured data=0.
- Mux (combinational): host_req=1 -> mem_addr/we/wdata = host_*. Otherwise mem_addr=scrub_addr, mem_we=(state==WR), mem_wdata=captured data.
- IDLE:
  - If enable=1, decrement wait counter each cycle.
  - Counter at 0 -> RD and reload INTERVAL-1.
  - enable=0 holds the counter.
- RD:
  - If host_req=1, stall in RD; nothing sampled.
  - Otherwise sample mem_rdata into captured data at the clock edge.
  - If mem_err=1 -> WR; else advance address, then IDLE.
- WR:
  - If host_req=1, stall. If also host_we=1 and host_addr==scrub_addr, cancel the write-back (host data is newer): advance address, then IDLE, and err_count is NOT incremented.
  - Otherwise mem_we=1 for exactly one cycle; err_count increments, saturating at 2^CNT_W-1; advance address, then IDLE.
- Address advance: scrub_addr+1, wrapping from 2^ADDR_W-1 to 0. On the wrap, pass_done=1 for the following cycle only.
- enable dropping in RD/WR: the current word completes, then the FSM holds in IDLE.
- Read-to-write latency: WR is asserted the cycle after an unstalled RD. Minimum spacing between word starts is INTERVAL+1 cycles (no error) or INTERVAL+2 cycles (error).
- Reset mid-WR: mem_we drops immediately (async); no partial state survives.

Test Plan:
- Clean array, enable=1, INTERVAL=16, ADDR_W=4 -> 16 reads, no mem_we from scrubber, pass_done pulses once after ~16*17 cycles, err_count=0.
- Force mem_err=1 at addr 5 with mem_rdata=8'hA5 -> one WR cycle, mem_addr=5, mem_wdata=8'hA5, err_count=1.
- host_req held 3 cycles during RD at addr 2 -> scrubber stalls 3 cycles, host sees its own addr/rdata; scrub resumes at addr 2 and samples afterwards.
- Host write to addr 7 during a pending WR to addr 7 -> no scrubber write, err_count unchanged, scrub_addr->8.
- mem_err forced on every word for 300 words with CNT_W=8 -> err_count saturates at 255 and stays.
- rst_n pulsed low during WR -> mem_we falls immediately; outputs return to reset values; the next scrub starts at addr 0 after INTERVAL cycles.
